// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over a UART (8N1, LSB first)
// and writes it word by word into the instruction ROM while holding the
// RISC-V core in reset. Image format: N (16-bit word count, low byte first),
// then 4*N payload bytes, each group of 4 forming one little-endian word.
//
// Optional feature: define LOADER_CHECKSUM_EN to append one checksum byte
// (XOR of all payload bytes) that must match before the core is released.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   uart_rxd      serial receive line, idle high
//   rom_w_en      ROM write strobe (one cycle per word)
//   rom_w_addr    ROM byte address of the word being written
//   rom_w_data    word being written
//   core_rst_o    holds the core in reset until the image is loaded
//   load_busy_o   load in progress (first byte seen, not yet complete)
//   load_done_o   sticky, image fully loaded
//   load_err_o    sticky, framing or checksum error
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic        rom_w_en,
  output logic [31:0] rom_w_addr,
  output logic [31:0] rom_w_data,
  output logic        core_rst_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned FRAME = 10 * DIV;
  localparam int unsigned CNT_W = $clog2(FRAME + 1);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_state_t;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_last;
  logic             armed;
  logic [CNT_W-1:0] idle_cnt;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  ld_state_t        ld_state;
  logic [15:0]      word_num;
  logic [15:0]      word_idx;
  logic [1:0]       byte_sel;
  logic [23:0]      word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  // After reset the receiver stays disarmed until the line has been idle
  // for a full frame, so a byte already in flight cannot be mis-framed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      idle_cnt <= '0;
    end else if (!armed) begin
      if (!rx_sync) begin
        idle_cnt <= '0;
      end else if (idle_cnt == FRAME_LAST) begin
        armed <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

  // UART receive FSM; byte_valid / frame_err are one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (armed && rx_last && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: length, payload words, optional checksum, then release core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state    <= LD_LEN0;
      word_num    <= '0;
      word_idx    <= '0;
      byte_sel    <= '0;
      word_buf    <= '0;
      rom_w_en    <= 1'b0;
      rom_w_addr  <= '0;
      rom_w_data  <= '0;
      core_rst_o  <= 1'b1;
      load_busy_o <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      rom_w_en   <= 1'b0;
      rom_w_addr <= '0;
      rom_w_data <= '0;
      // Framing errors abort any load still in progress
      if (frame_err && ld_state != LD_DONE && ld_state != LD_ERR) begin
        ld_state    <= LD_ERR;
        load_err_o  <= 1'b1;
        load_busy_o <= 1'b0;
      end else begin
        case (ld_state)
          LD_LEN0: begin
            if (byte_valid) begin
              word_num[7:0] <= rx_byte;
              load_busy_o   <= 1'b1;
              ld_state      <= LD_LEN1;
            end
          end
          LD_LEN1: begin
            if (byte_valid) begin
              word_num[15:8] <= rx_byte;
              word_idx       <= '0;
              byte_sel       <= '0;
              ld_state       <= ({rx_byte, word_num[7:0]} == 16'd0) ? LD_CSUM : LD_DATA;
            end
          end
          LD_DATA: begin
            if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
              csum <= csum ^ rx_byte;
`endif
              byte_sel <= byte_sel + 2'd1;
              // Bytes shift in from the top so byte0 lands in bits 7:0
              word_buf <= {rx_byte, word_buf[23:8]};
              if (byte_sel == 2'd3) begin
                rom_w_en   <= 1'b1;
                rom_w_addr <= {14'd0, word_idx, 2'b00};
                rom_w_data <= {rx_byte, word_buf};
                if (word_idx == word_num - 16'd1) ld_state <= LD_CSUM;
                else                              word_idx <= word_idx + 16'd1;
              end
            end
          end
          LD_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (byte_valid) begin
              if (rx_byte == csum) begin
                ld_state    <= LD_DONE;
                core_rst_o  <= 1'b0;
                load_done_o <= 1'b1;
                load_busy_o <= 1'b0;
              end else begin
                ld_state    <= LD_ERR;
                load_err_o  <= 1'b1;
                load_busy_o <= 1'b0;
              end
            end
`else
            ld_state    <= LD_DONE;
            core_rst_o  <= 1'b0;
            load_done_o <= 1'b1;
            load_busy_o <= 1'b0;
`endif
          end
          LD_DONE: ;
          LD_ERR:  ;
          default: ld_state <= LD_ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader (DIV = 10 clocks per bit).
module tb_uart_boot_loader;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        rom_w_en;
  logic [31:0] rom_w_addr;
  logic [31:0] rom_w_data;
  logic        core_rst_o;
  logic        load_busy_o;
  logic        load_done_o;
  logic        load_err_o;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int zero_viol = 0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  uart_boot_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .rom_w_en    (rom_w_en),
    .rom_w_addr  (rom_w_addr),
    .rom_w_data  (rom_w_data),
    .core_rst_o  (core_rst_o),
    .load_busy_o (load_busy_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle; also flags non-zero bus values without a strobe
  always @(negedge clk) begin
    if (rst) begin
      wr_count = 0;
    end else if (rom_w_en) begin
      if (wr_count < 16) begin
        wr_addr[wr_count] = rom_w_addr;
        wr_data[wr_count] = rom_w_data;
      end
      wr_count = wr_count + 1;
    end else if (rom_w_addr != 32'd0 || rom_w_data != 32'd0) begin
      zero_viol = zero_viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      idle(DIV);
    end
    uart_rxd = stop_bit;
    idle(DIV);
    uart_rxd = 1'b1;
    idle(DIV);
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(10 * DIV + 10);
  endtask

  initial begin
    bq_t img1;
    bq_t img3;
    bq_t img0;

    img1 = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    img3 = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
             8'h6F, 8'hF0, 8'hDF, 8'hFF};
    img0 = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    img1.push_back(8'h08);
    img3.push_back(8'h2F);
    img0.push_back(8'h00);
`endif

    // Reset values
    rst = 1'b1;
    idle(3);
    chk("rst_core_rst", 32'(core_rst_o), 32'd1);
    chk("rst_w_en", 32'(rom_w_en), 32'd0);
    chk("rst_w_addr", rom_w_addr, 32'd0);
    chk("rst_w_data", rom_w_data, 32'd0);
    chk("rst_busy", 32'(load_busy_o), 32'd0);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_err", 32'(load_err_o), 32'd0);
    rst = 1'b0;
    idle(10 * DIV + 10);

    // Single-word image
    send_byte(img1[0], 1'b1);
    chk("t1_busy_after_len0", 32'(load_busy_o), 32'd1);
    chk("t1_core_rst_loading", 32'(core_rst_o), 32'd1);
    for (int i = 1; i < img1.size(); i++) send_byte(img1[i], 1'b1);
    idle(5);
    chk("t1_wr_count", 32'(wr_count), 32'd1);
    chk("t1_addr0", wr_addr[0], 32'h0);
    chk("t1_data0", wr_data[0], 32'h12345678);
    chk("t1_core_rst", 32'(core_rst_o), 32'd0);
    chk("t1_done", 32'(load_done_o), 32'd1);
    chk("t1_busy", 32'(load_busy_o), 32'd0);
    chk("t1_err", 32'(load_err_o), 32'd0);
    send_q('{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    chk("t1_ignored_wr_count", 32'(wr_count), 32'd1);
    chk("t1_still_done", 32'(load_done_o), 32'd1);

    // Short glitch is a false start, then a three-word image
    do_reset();
    chk("t2_rst_core_rst", 32'(core_rst_o), 32'd1);
    chk("t2_rst_done", 32'(load_done_o), 32'd0);
    uart_rxd = 1'b0;
    idle(3);
    uart_rxd = 1'b1;
    idle(3 * DIV);
    chk("t2_glitch_busy", 32'(load_busy_o), 32'd0);
    chk("t2_glitch_wr", 32'(wr_count), 32'd0);
    send_q(img3);
    idle(5);
    chk("t2_wr_count", 32'(wr_count), 32'd3);
    chk("t2_addr0", wr_addr[0], 32'h0);
    chk("t2_data0", wr_data[0], 32'h00000013);
    chk("t2_addr1", wr_addr[1], 32'h4);
    chk("t2_data1", wr_data[1], 32'h00100093);
    chk("t2_addr2", wr_addr[2], 32'h8);
    chk("t2_data2", wr_data[2], 32'hFFDFF06F);
    chk("t2_done", 32'(load_done_o), 32'd1);
    chk("t2_core_rst", 32'(core_rst_o), 32'd0);

    // Framing error on the third byte
    do_reset();
    send_q('{8'h01, 8'h00});
    send_byte(8'hAA, 1'b0);
    idle(5);
    chk("t3_err", 32'(load_err_o), 32'd1);
    chk("t3_core_rst", 32'(core_rst_o), 32'd1);
    send_q('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    idle(5);
    chk("t3_no_writes", 32'(wr_count), 32'd0);
    chk("t3_done", 32'(load_done_o), 32'd0);
    chk("t3_err_sticky", 32'(load_err_o), 32'd1);
    chk("t3_core_rst_after", 32'(core_rst_o), 32'd1);

    // Reset in the middle of a load, then a clean reload
    do_reset();
    chk("t4_err_cleared", 32'(load_err_o), 32'd0);
    send_q('{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h99});
    chk("t4_partial_wr", 32'(wr_count), 32'd1);
    chk("t4_partial_data", wr_data[0], 32'hEFBEADDE);
    chk("t4_partial_busy", 32'(load_busy_o), 32'd1);
    do_reset();
    chk("t4_rst_busy", 32'(load_busy_o), 32'd0);
    send_q(img1);
    idle(5);
    chk("t4_wr_count", 32'(wr_count), 32'd1);
    chk("t4_addr0", wr_addr[0], 32'h0);
    chk("t4_data0", wr_data[0], 32'h12345678);
    chk("t4_done", 32'(load_done_o), 32'd1);
    chk("t4_err", 32'(load_err_o), 32'd0);

    // Empty image goes straight to done
    do_reset();
    send_q(img0);
    idle(5);
    chk("t5_wr_count", 32'(wr_count), 32'd0);
    chk("t5_done", 32'(load_done_o), 32'd1);
    chk("t5_core_rst", 32'(core_rst_o), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum
    do_reset();
    send_q('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09});
    idle(5);
    chk("t6_err", 32'(load_err_o), 32'd1);
    chk("t6_done", 32'(load_done_o), 32'd0);
    chk("t6_core_rst", 32'(core_rst_o), 32'd1);
`endif

    chk("bus_zero_without_strobe", 32'(zero_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; DIV = CLK_FREQ/BAUD, integer-truncated.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 uart_rxd  input  1  serial receive line; idle high; format 8N1, LSB first.
REQ-006 rom_w_en  output  1  instruction-ROM write strobe, one cycle per word.
REQ-007 rom_w_addr  output  32  ROM byte address of the word being written.
REQ-008 rom_w_data  output  32  word being written, assembled little-endian.
REQ-009 core_rst_o  output  1  holds the RISC-V core in reset while high.
REQ-010 load_busy_o  output  1  high while the first byte has been received and the load is not yet complete.
REQ-011 load_done_o  output  1  sticky; high once the image is fully loaded.
REQ-012 load_err_o  output  1  sticky; high on a framing or checksum error.

Function
REQ-013 uart_rxd SHALL pass through a two-flop synchronizer (reset value 1) before any use.
REQ-014 The RX FSM SHALL use states IDLE, START, DATA and STOP, with a bit-timer counter and a 3-bit bit index.
- IDLE -> START: on a synchronized falling edge.
- START: sample at DIV/2 cycles; if high (false start) -> IDLE, else -> DATA.
- DATA: sample every DIV cycles; 8 bits stored LSB first; after bit 7 -> STOP.
REQ-015 STOP SHALL sample after DIV cycles.
- Sample 1: byte_valid pulses for one cycle on the next clock.
- Sample 0: framing error; the byte is discarded; the loader enters ERR.
- In both cases the RX FSM returns to IDLE.
REQ-016 The loader FSM SHALL use states LEN0, LEN1, DATA, CSUM, DONE and ERR, with LEN0 entered from reset.
REQ-017 LEN0 and LEN1 SHALL capture the 16-bit word count N, low byte first.
REQ-018 After LEN1, N=0 SHALL go to CSUM; otherwise the FSM goes to DATA.
REQ-019 In DATA, each group of 4 bytes SHALL form one word (byte0 = bits 7:0).
- rom_w_en is asserted one cycle after the 4th byte's byte_valid.
- rom_w_addr = 4*k for word index k = 0..N-1.
- rom_w_data holds the word in that same cycle.
REQ-020 After word N-1 is written, the FSM SHALL go to CSUM; rom_w_addr never exceeds 4*(N-1) (maximum 0x3FFF8 when N = 65535).
REQ-021 rom_w_en, rom_w_addr and rom_w_data SHALL be 0 in every cycle without a write.
REQ-022 In DONE: core_rst_o is 0, load_done_o is 1, load_busy_o is 0, and all further UART bytes are ignored with no writes.
REQ-023 In ERR: core_rst_o is 1, load_err_o is 1, and no further writes occur; only rst exits ERR.
REQ-024 core_rst_o SHALL be 1 in every state except DONE.
- It goes low on the same edge that enters DONE.
- The ROM is therefore never read by a running core during a load.
REQ-025 A byte_valid pulse SHALL be consumed by exactly one loader transition; back-to-back bytes at full baud SHALL lose no data.

Reset
REQ-026 Asserting rst SHALL, at any time, return both FSMs to IDLE and LEN0 asynchronously.
- A partially assembled word and the byte counter are discarded.
- Reset values: core_rst_o = 1; rom_w_en, rom_w_addr, rom_w_data, load_busy_o, load_done_o and load_err_o = 0.
REQ-027 A byte in flight when rst deasserts SHALL be ignored until the line has been idle high for one full frame (10*DIV cycles).

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN SHALL select the behaviour of CSUM.
- Defined: CSUM waits for one byte and compares it with the XOR of all payload bytes (length bytes excluded, N=0 gives 0x00); a match -> DONE, a mismatch -> ERR.
- Undefined: CSUM passes straight to DONE on the next cycle with no byte consumed, and no checksum logic is built.

Verification
REQ-029 Bytes 01 00 78 56 34 12 [+ checksum 0x08] -> one rom_w_en with addr 0x0, data 0x12345678; then core_rst_o=0 and load_done_o=1.
REQ-030 N=3 with words 0x00000013, 0x00100093, 0xFFDFF06F -> writes at addresses 0x0, 0x4 and 0x8 in order, exactly 3 strobes.
REQ-031 A 0.3-bit low glitch on uart_rxd in IDLE -> false start; no byte is received and the state is unchanged.
REQ-032 Stop bit forced to 0 on the 3rd byte -> load_err_o=1, core_rst_o stays 1, and no writes occur afterwards.
REQ-033 rst pulsed after 5 payload bytes, then a full valid image is sent -> a correct load from address 0x0 with no residue of the aborted load.
REQ-034 With LOADER_CHECKSUM_EN, checksum 0x09 sent instead of 0x08 for the REQ-029 image -> load_err_o=1 and load_done_o=0.
